// File: rtl/path_planner_pkg.sv
// Shared widths, sentinel values, response status codes and scheduler FSM
// encodings for the path planner and its query scheduler.
package path_planner_pkg;

  localparam int NODE_W = 5;
  localparam int PATH_W = 50;
  localparam logic [NODE_W-1:0] NO_PRED = 5'd27;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_BADNODE = 2'd1,
    ST_TIMEOUT = 2'd2
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PP_RST,
    S_LAUNCH,
    S_WAIT,
    S_RESPOND
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping modulo N, as a one-hot vector plus its index.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  int   idx;
  logic found;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, so no path leaves a value held and no latch appears.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/path_query_scheduler.sv
// Shares one path planner among N_REQ requesters: round-robin accept, planner
// reset/launch, wait for done or timeout, single tagged response channel.
module path_query_scheduler
  import path_planner_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int NODE_COUNT     = 19,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [NODE_W*N_REQ-1:0]   req_s_node,
  input  logic [NODE_W*N_REQ-1:0]   req_e_node,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [2:0]                rsp_id,
  output logic [1:0]                rsp_status,
  output logic [PATH_W-1:0]         rsp_path,
  output logic [31:0]               rsp_cycles,
  output logic                      busy,
  output logic                      pp_reset,
  output logic                      pp_start,
  output logic [NODE_W-1:0]         pp_s_node,
  output logic [NODE_W-1:0]         pp_e_node,
  input  logic                      pp_done,
  input  logic [PATH_W-1:0]         pp_final_path
);

  localparam int ID_W = $clog2(N_REQ);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d, id_q, id_d, gnt_idx;
  logic [N_REQ-1:0]  gnt;
  logic [NODE_W-1:0] s_q, s_d, e_q, e_d, sel_s, sel_e;
  logic [31:0]       cnt_q, cnt_d, rst_cnt_q, rst_cnt_d, cycles_q, cycles_d;
  status_e           status_q, status_d;
  logic [PATH_W-1:0] path_q, path_d;
  logic              accept, bad_node;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (gnt),
    .grant_idx (gnt_idx)
  );

  // Grants are only offered while idle and out of reset, so one query is in flight.
  assign req_ready = (state_q == S_IDLE && !reset) ? gnt : '0;
  assign accept    = |(req_valid & req_ready);
  assign sel_s     = req_s_node[gnt_idx*NODE_W +: NODE_W];
  assign sel_e     = req_e_node[gnt_idx*NODE_W +: NODE_W];
  assign bad_node  = (int'(sel_s) >= NODE_COUNT) || (int'(sel_e) >= NODE_COUNT);

  assign rsp_valid  = (state_q == S_RESPOND);
  assign busy       = (state_q != S_IDLE);
  assign pp_start   = (state_q == S_LAUNCH);
  assign pp_reset   = reset | (state_q == S_PP_RST);
  assign pp_s_node  = s_q;
  assign pp_e_node  = e_q;
  assign rsp_id     = 3'(id_q);
  assign rsp_status = status_q;
  assign rsp_path   = path_q;
  assign rsp_cycles = cycles_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    s_d       = s_q;
    e_d       = e_q;
    cnt_d     = cnt_q;
    rst_cnt_d = rst_cnt_q;
    status_d  = status_q;
    path_d    = path_q;
    cycles_d  = cycles_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          id_d  = gnt_idx;
          ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          if (bad_node) begin
            // Planner inputs are left untouched for a rejected query.
            status_d = ST_BADNODE;
            path_d   = '0;
            cycles_d = '0;
            state_d  = S_RESPOND;
          end else begin
            s_d       = sel_s;
            e_d       = sel_e;
            rst_cnt_d = '0;
            state_d   = S_PP_RST;
          end
        end
      end
      S_PP_RST: begin
        if (rst_cnt_q == 32'(RST_CYCLES - 1)) state_d = S_LAUNCH;
        else                                  rst_cnt_d = rst_cnt_q + 1'b1;
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (pp_done) begin
          status_d = ST_OK;
          path_d   = pp_final_path;
          cycles_d = cnt_q;
          state_d  = S_RESPOND;
        end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          status_d = ST_TIMEOUT;
          path_d   = '0;
          cycles_d = cnt_q;
          state_d  = S_RESPOND;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESPOND: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      s_q       <= '0;
      e_q       <= '0;
      cnt_q     <= '0;
      rst_cnt_q <= '0;
      status_q  <= ST_OK;
      path_q    <= '0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      s_q       <= s_d;
      e_q       <= e_d;
      cnt_q     <= cnt_d;
      rst_cnt_q <= rst_cnt_d;
      status_q  <= status_d;
      path_q    <= path_d;
      cycles_q  <= cycles_d;
    end
  end

endmodule

// File: tb/tb_path_query_scheduler.sv
// Bench for path_query_scheduler: stub planner, queue-level reference model of
// round-robin service, response timing and payload, directed plus random traffic.
module tb_path_query_scheduler;
  import path_planner_pkg::*;

  localparam int N   = 4;
  localparam int NC  = 19;
  localparam int RST = 2;
  localparam int TO  = 64;
  localparam logic [1:0] E_OK = 2'd0, E_BAD = 2'd1, E_TMO = 2'd2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0, req_ready;
  logic [5*N-1:0] req_s_node = '0, req_e_node = '0;
  logic           rsp_valid, rsp_ready = 1'b0;
  logic [2:0]     rsp_id;
  logic [1:0]     rsp_status;
  logic [49:0]    rsp_path;
  logic [31:0]    rsp_cycles;
  logic           busy, pp_reset, pp_start, pp_done;
  logic [4:0]     pp_s_node, pp_e_node;
  logic [49:0]    pp_final_path;

  always #5 clk = ~clk;

  path_query_scheduler #(
    .N_REQ(N), .NODE_COUNT(NC), .RST_CYCLES(RST), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_s_node(req_s_node), .req_e_node(req_e_node), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_status(rsp_status),
    .rsp_path(rsp_path), .rsp_cycles(rsp_cycles), .busy(busy),
    .pp_reset(pp_reset), .pp_start(pp_start), .pp_s_node(pp_s_node), .pp_e_node(pp_e_node),
    .pp_done(pp_done), .pp_final_path(pp_final_path)
  );

  // Stub planner: done after a node-dependent latency, path word derived from the nodes.
  function automatic int lat_of(logic [4:0] s, logic [4:0] e);
    return (int'(s) * 3 + int'(e) * 5) % 13;
  endfunction

  function automatic logic [49:0] path_of(logic [4:0] s, logic [4:0] e);
    if (s == 5'd0 && e == 5'd5) return {{7{NO_PRED}}, 5'd0, 5'd1, 5'd5};
    return {s, e, s ^ e, ~s, 5'(s + e), 25'(int'(s) * 1000 + int'(e))};
  endfunction

  logic stub_run;
  int   stub_age;
  bit   stub_hang = 1'b0;

  always_ff @(posedge clk) begin
    if (pp_reset) begin
      stub_run <= 1'b0;
      stub_age <= 0;
    end else if (pp_start) begin
      stub_run <= 1'b1;
      stub_age <= 0;
    end else if (stub_run && stub_age < 100000) begin
      stub_age <= stub_age + 1;
    end
  end

  assign pp_done       = stub_run && !stub_hang && (stub_age >= lat_of(pp_s_node, pp_e_node));
  assign pp_final_path = stub_run ? path_of(pp_s_node, pp_e_node) : '0;

  typedef struct {
    int          id;
    logic [1:0]  status;
    logic [49:0] path;
    int          cycles;
    int          due;
    logic [4:0]  s, e;
  } exp_t;

  int          n_checks = 0, n_fails = 0;
  logic [N-1:0] pend = '0;
  logic [4:0]  ps [N];
  logic [4:0]  pe [N];
  exp_t        cur;
  bit          outstanding = 1'b0, rand_ready = 1'b0;
  int          ptr_m = 0, hold = 0, cyc = 0, n_starts = 0, n_rsts = 0;
  int          dut_log[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic check_reset_values();
    check("rst_req_ready",  64'(req_ready),  64'(0));
    check("rst_rsp_valid",  64'(rsp_valid),  64'(0));
    check("rst_rsp_id",     64'(rsp_id),     64'(0));
    check("rst_rsp_status", 64'(rsp_status), 64'(0));
    check("rst_rsp_path",   64'(rsp_path),   64'(0));
    check("rst_rsp_cycles", 64'(rsp_cycles), 64'(0));
    check("rst_busy",       64'(busy),       64'(0));
    check("rst_pp_start",   64'(pp_start),   64'(0));
    check("rst_pp_s_node",  64'(pp_s_node),  64'(0));
    check("rst_pp_e_node",  64'(pp_e_node),  64'(0));
    check("rst_pp_reset",   64'(pp_reset),   64'(1));
  endtask

  // Called at a negedge; requesters stay valid during reset to show grants are suppressed.
  task automatic do_reset(input int cycles);
    reset     = 1'b1;
    pend      = '0;
    rsp_ready = 1'b0;
    req_valid = '1;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    cyc++;
    check_reset_values();
    req_valid   = '0;
    reset       = 1'b0;
    outstanding = 1'b0;
    ptr_m       = 0;
    hold        = 0;
  endtask

  // One clock cycle: drive, compare against the model, advance the model at the edge.
  task automatic step();
    logic [N-1:0] exp_rdy;
    int pick;
    bit done_hs;
    for (int r = 0; r < N; r++) begin
      req_valid[r]         = pend[r];
      req_s_node[5*r +: 5] = ps[r];
      req_e_node[5*r +: 5] = pe[r];
    end
    #1;
    if (hold > 0 && rsp_valid) begin
      rsp_ready = 1'b0;
      hold--;
    end else begin
      rsp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    #1;
    exp_rdy = '0;
    pick    = -1;
    if (!outstanding)
      for (int k = 0; k < N; k++)
        if (pick < 0 && pend[(ptr_m + k) % N]) pick = (ptr_m + k) % N;
    if (pick >= 0) exp_rdy[pick] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("rsp_valid", 64'(rsp_valid), 64'(outstanding && cyc >= cur.due));
    check("busy",      64'(busy),      64'(outstanding));
    for (int r = 0; r < N; r++)
      if (req_valid[r] && req_ready[r]) dut_log.push_back(r);
    done_hs = 1'b0;
    if (outstanding && cyc >= cur.due && rsp_valid) begin
      check("rsp_id",     64'(rsp_id),     64'(cur.id));
      check("rsp_status", 64'(rsp_status), 64'(cur.status));
      check("rsp_path",   64'(rsp_path),   64'(cur.path));
      check("rsp_cycles", 64'(rsp_cycles), 64'(cur.cycles));
      if (rsp_ready) begin
        if (cur.status == E_BAD) begin
          check("bad_no_pp_start", 64'(n_starts), 64'(0));
          check("bad_no_pp_reset", 64'(n_rsts),   64'(0));
        end else begin
          check("pp_start_pulses", 64'(n_starts),  64'(1));
          check("pp_reset_cycles", 64'(n_rsts),    64'(RST));
          check("pp_s_node",       64'(pp_s_node), 64'(cur.s));
          check("pp_e_node",       64'(pp_e_node), 64'(cur.e));
        end
        done_hs = 1'b1;
      end
    end
    @(posedge clk);
    if (pick >= 0) begin
      pend[pick]  = 1'b0;
      outstanding = 1'b1;
      ptr_m       = (pick + 1) % N;
      cur.id      = pick;
      cur.s       = ps[pick];
      cur.e       = pe[pick];
      n_starts    = 0;
      n_rsts      = 0;
      if (int'(cur.s) >= NC || int'(cur.e) >= NC) begin
        cur.status = E_BAD;
        cur.path   = '0;
        cur.cycles = 0;
        cur.due    = cyc + 1;
      end else if (stub_hang) begin
        cur.status = E_TMO;
        cur.path   = '0;
        cur.cycles = TO - 1;
        cur.due    = cyc + RST + 3 + TO - 1;
      end else begin
        cur.status = E_OK;
        cur.path   = path_of(cur.s, cur.e);
        cur.cycles = lat_of(cur.s, cur.e);
        cur.due    = cyc + RST + 3 + cur.cycles;
      end
    end
    if (done_hs) outstanding = 1'b0;
    @(negedge clk);
    cyc++;
    if (outstanding) begin
      n_starts += int'(pp_start);
      n_rsts   += int'(pp_reset);
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((outstanding || (|pend)) && guard < 3000) begin
      step();
      guard++;
    end
    check("drain_budget", 64'(outstanding || (|pend)), 64'(0));
  endtask

  task automatic wait_accept();
    int guard = 0;
    while (!outstanding && guard < 50) begin
      step();
      guard++;
    end
    check("accept_budget", 64'(outstanding), 64'(1));
  endtask

  task automatic post(input int r, input int s, input int e);
    pend[r] = 1'b1;
    ps[r]   = 5'(s);
    pe[r]   = 5'(e);
  endtask

  initial begin
    int exp_order[6];
    exp_order = '{0, 1, 2, 3, 0, 2};
    for (int r = 0; r < N; r++) begin
      ps[r] = '0;
      pe[r] = '0;
    end
    @(negedge clk);
    do_reset(2);

    // Single OK query from requester 0.
    dut_log.delete();
    post(0, 0, 5);
    wait_idle();
    check("t1_grant_count", 64'(dut_log.size()), 64'(1));

    // All requesters at once, then 0 and 2 again.
    do_reset(1);
    dut_log.delete();
    for (int r = 0; r < N; r++) post(r, r, r + 1);
    wait_idle();
    post(0, 5, 9);
    post(2, 2, 18);
    wait_idle();
    check("t2_grant_count", 64'(dut_log.size()), 64'(6));
    for (int i = 0; i < 6 && i < dut_log.size(); i++)
      check("t2_grant_order", 64'(dut_log[i]), 64'(exp_order[i]));

    // Out-of-range start node.
    post(2, 20, 3);
    wait_idle();

    // Planner that never finishes, then a normal query.
    stub_hang = 1'b1;
    post(1, 4, 9);
    wait_idle();
    stub_hang = 1'b0;
    post(1, 4, 9);
    wait_idle();

    // Consumer stalls for 10 cycles while new requests arrive.
    hold = 10;
    post(3, 1, 2);
    wait_accept();
    post(0, 2, 7);
    post(1, 7, 2);
    wait_idle();
    check("t5_stall_consumed", 64'(hold), 64'(0));

    // Reset while waiting on the planner.
    stub_hang = 1'b1;
    post(1, 3, 4);
    wait_accept();
    repeat (6) step();
    do_reset(1);
    stub_hang = 1'b0;
    repeat (20) step();
    post(1, 3, 4);
    wait_idle();

    // Random traffic including out-of-range nodes and random consumer backpressure.
    rand_ready = 1'b1;
    for (int c = 0; c < 600; c++) begin
      for (int r = 0; r < N; r++)
        if (!pend[r] && $urandom_range(0, 5) == 0)
          post(r, int'($urandom_range(0, 22)), int'($urandom_range(0, 22)));
      step();
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
